// File: rtl/hbridge_pwm_pkg.sv
// hbridge_pwm_pkg: shared state encoding, bridge output codes and duty helpers for hbridge_pwm
package hbridge_pwm_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_REV_DOWN, ST_DEAD, ST_BRAKE} ch_state_e;
  localparam logic [1:0] MA_COAST = 2'b00;
  localparam logic [1:0] MA_BRAKE = 2'b11;
  function automatic logic [31:0] clamp_duty(input logic [31:0] v, input logic [31:0] lim);
    return (v > lim) ? lim : v;
  endfunction
  // Moves cur toward tgt by at most step and never overshoots.
  function automatic logic [31:0] ramp_toward(input logic [31:0] cur, input logic [31:0] tgt, input logic [31:0] step);
    if (cur < tgt) return (tgt - cur > step) ? cur + step : tgt;
    return (cur - tgt > step) ? cur - step : tgt;
  endfunction
endpackage

// File: rtl/hbridge_pwm_ch.sv
// hbridge_pwm_ch: one H-bridge channel with FSM, duty ramp, dead-time and registered drive
// in: enable/direct/brake commands, duty_tgt, shared cnt and ramp_tick
// out: ma bridge drive, duty_cur ramped duty, at_target
module hbridge_pwm_ch
  import hbridge_pwm_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PERIOD    = 10000,
  parameter int DUTY_STEP = 1000,
  parameter int DEAD      = 50
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             enable,
  input  logic             direct,
  input  logic             brake,
  input  logic [CNT_W-1:0] duty_tgt,
  input  logic [CNT_W-1:0] cnt,
  input  logic             ramp_tick,
  output logic [1:0]       ma,
  output logic [CNT_W-1:0] duty_cur,
  output logic             at_target
);
  localparam int DW = $clog2(DEAD + 1);
  ch_state_e state, state_d, dest, dest_d;
  logic dir_lat, dir_d, pwm, driving, at_target_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic [CNT_W-1:0] duty_app, duty_app_d, duty_cur_d, eff_tgt, ramp_tgt;
  logic [1:0] ma_d;
  assign eff_tgt = CNT_W'(clamp_duty(32'(duty_tgt), 32'(PERIOD)));
  // A pending reversal forces the ramp toward zero.
  assign ramp_tgt = (direct == dir_lat) ? eff_tgt : '0;
  assign pwm = cnt < duty_app;
  assign driving = state == ST_RUN || state == ST_REV_DOWN;
  always_comb begin
    state_d = state;
    dest_d = dest;
    dir_d = dir_lat;
    dcnt_d = '0;
    if (!enable) state_d = ST_IDLE;
    else case (state)
      ST_IDLE: if (!brake) begin
        state_d = ST_RUN;
        dir_d = direct;
      end
      ST_RUN, ST_REV_DOWN:
        if (brake) begin
          state_d = ST_DEAD;
          dest_d = ST_BRAKE;
        end else if (direct == dir_lat) state_d = ST_RUN;
        else if (state == ST_REV_DOWN && duty_cur == '0 && duty_app == '0) begin
          state_d = ST_DEAD;
          dest_d = ST_RUN;
        end else state_d = ST_REV_DOWN;
      ST_DEAD:
        if (dcnt == DW'(DEAD - 1)) begin
          dir_d = direct;
          state_d = (dest == ST_BRAKE && !brake) ? ST_IDLE : dest;
        end else dcnt_d = dcnt + 1'b1;
      ST_BRAKE: if (!brake) begin
        state_d = ST_DEAD;
        dest_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign duty_cur_d = !(enable && driving && !brake) ? '0 :
                      ramp_tick ? CNT_W'(ramp_toward(32'(duty_cur), 32'(ramp_tgt), 32'(DUTY_STEP))) : duty_cur;
  // The applied duty only changes at the period wrap so no period is truncated.
  assign duty_app_d = !(state_d == ST_RUN || state_d == ST_REV_DOWN) ? '0 :
                      (cnt == CNT_W'(PERIOD - 1)) ? duty_cur : duty_app;
  assign at_target_d = state_d == ST_RUN && duty_cur_d == eff_tgt;
  assign ma_d = !enable ? MA_COAST :
                driving ? (dir_lat ? {1'b0, pwm} : {pwm, 1'b0}) :
                state == ST_BRAKE ? MA_BRAKE : MA_COAST;
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= ST_IDLE;
      dest <= ST_IDLE;
      dir_lat <= 1'b1;
      dcnt <= '0;
      duty_cur <= '0;
      duty_app <= '0;
      at_target <= 1'b0;
      ma <= MA_COAST;
    end else begin
      state <= state_d;
      dest <= dest_d;
      dir_lat <= dir_d;
      dcnt <= dcnt_d;
      duty_cur <= duty_cur_d;
      duty_app <= duty_app_d;
      at_target <= at_target_d;
      ma <= ma_d;
    end
  end
endmodule

// File: rtl/hbridge_pwm.sv
// hbridge_pwm: multi-channel H-bridge PWM driver with shared period/ramp counters
// in: enable/direct/brake per channel, duty_tgt packed CNT_W per channel
// out: MA 2 bits per channel, duty_cur packed CNT_W per channel, at_target per channel
module hbridge_pwm
  import hbridge_pwm_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 16,
  parameter int PERIOD    = 10000,
  parameter int RAMP_DIV  = 25000,
  parameter int DUTY_STEP = 1000,
  parameter int DEAD      = 50
) (
  input  logic                  sclk,
  input  logic                  s_rst_n,
  input  logic [N_CH-1:0]       enable,
  input  logic [N_CH-1:0]       direct,
  input  logic [N_CH-1:0]       brake,
  input  logic [N_CH*CNT_W-1:0] duty_tgt,
  output logic [2*N_CH-1:0]     MA,
  output logic [N_CH*CNT_W-1:0] duty_cur,
  output logic [N_CH-1:0]       at_target
);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  logic [CNT_W-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic ramp_tick;
  assign ramp_tick = rcnt == RW'(RAMP_DIV - 1);
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt <= '0;
      rcnt <= '0;
    end else begin
      cnt <= (cnt == CNT_W'(PERIOD - 1)) ? '0 : cnt + 1'b1;
      rcnt <= ramp_tick ? '0 : rcnt + 1'b1;
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    hbridge_pwm_ch #(
      .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_STEP(DUTY_STEP), .DEAD(DEAD)
    ) u_ch (
      .sclk(sclk),
      .s_rst_n(s_rst_n),
      .enable(enable[k]),
      .direct(direct[k]),
      .brake(brake[k]),
      .duty_tgt(duty_tgt[k*CNT_W +: CNT_W]),
      .cnt(cnt),
      .ramp_tick(ramp_tick),
      .ma(MA[2*k +: 2]),
      .duty_cur(duty_cur[k*CNT_W +: CNT_W]),
      .at_target(at_target[k])
    );
  end
endmodule

// File: tb/tb_hbridge_pwm.sv
// tb_hbridge_pwm: directed self-checking bench for hbridge_pwm
module tb_hbridge_pwm;
  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;
  logic [1:0] enable = '0, direct = '0, brake = '0;
  logic [31:0] duty_tgt = '0;
  logic [3:0] MA;
  logic [31:0] duty_cur;
  logic [1:0] at_target;
  int vectors = 0, miscompares = 0;
  hbridge_pwm #(
    .N_CH(2), .CNT_W(16), .PERIOD(100), .RAMP_DIV(10), .DUTY_STEP(10), .DEAD(4)
  ) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .enable(enable), .direct(direct), .brake(brake),
    .duty_tgt(duty_tgt), .MA(MA), .duty_cur(duty_cur), .at_target(at_target)
  );
  always #5 sclk = ~sclk;
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] duty_of(input int ch);
    return duty_cur[ch*16 +: 16];
  endfunction
  function automatic logic [1:0] ma_of(input int ch);
    return MA[2*ch +: 2];
  endfunction
  task automatic wait_duty(input int ch, input logic [15:0] v, input int budget, input string tag);
    int n = 0;
    while (duty_of(ch) !== v && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(duty_of(ch)), 32'(v));
  endtask
  task automatic wait_at(input int ch, input int budget, input string tag);
    int n = 0;
    while (at_target[ch] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(at_target[ch]), 32'd1);
  endtask
  task automatic count_ma(input int ch, input int cycles, output int c00, output int c01, output int c10, output int c11);
    c00 = 0; c01 = 0; c10 = 0; c11 = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      case (ma_of(ch))
        2'b00: c00++;
        2'b01: c01++;
        2'b10: c10++;
        default: c11++;
      endcase
    end
  endtask
  initial begin
    int c00, c01, c10, c11, n, o00, o01, o10, o11, mn;
    logic [15:0] prev;
    logic saw;
    logic [1:0] exp_on [8];
    logic [1:0] exp_off [7];
    exp_on = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
    exp_off = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    ticks(3);
    chk("reset_ma", 32'(MA), 0);
    chk("reset_duty", duty_cur, 0);
    chk("reset_at", 32'(at_target), 0);
    s_rst_n = 1'b1;
    tick();
    // forward ramp on ch0
    enable[0] = 1'b1; direct[0] = 1'b1; duty_tgt[15:0] = 16'd50;
    prev = '0;
    for (int k = 1; k <= 5; k++) begin
      n = 0;
      while (duty_of(0) === prev && n < 30) begin
        tick();
        n++;
      end
      chk("fwd_step", 32'(duty_of(0)), 32'(k * 10));
      if (k > 1) chk("fwd_interval", n, 10);
      chk("fwd_at_target", 32'(at_target[0]), 32'(k == 5));
      prev = duty_of(0);
    end
    ticks(110);
    fork
      count_ma(0, 100, c00, c01, c10, c11);
      count_ma(1, 100, o00, o01, o10, o11);
    join
    chk("fwd_high", c01, 50);
    chk("fwd_low", c00, 50);
    chk("fwd_other", c10 + c11, 0);
    chk("fwd_ch1_idle", o00, 100);
    // reversal on ch0
    direct[0] = 1'b0;
    for (int k = 4; k >= 0; k--) wait_duty(0, 16'(k * 10), 15, "rev_down");
    n = 0;
    saw = 1'b0;
    while (ma_of(0) !== 2'b10 && n < 400) begin
      tick();
      n++;
      if (ma_of(1) !== 2'b00 || ma_of(0) === 2'b11) saw = 1'b1;
    end
    chk("rev_drive", 32'(ma_of(0)), 2);
    chk("rev_clean", 32'(saw), 0);
    wait_at(0, 200, "rev_at");
    chk("rev_duty", 32'(duty_of(0)), 50);
    ticks(110);
    count_ma(0, 100, c00, c01, c10, c11);
    chk("rev_high", c10, 50);
    chk("rev_low", c00, 50);
    // brake on ch1 at full duty
    enable[1] = 1'b1; direct[1] = 1'b1; duty_tgt[31:16] = 16'd100;
    wait_at(1, 300, "brk_at");
    ticks(110);
    count_ma(1, 100, c00, c01, c10, c11);
    chk("full_high", c01, 100);
    brake[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("brake_on", 32'(ma_of(1)), 32'(exp_on[i]));
    end
    chk("brake_duty", 32'(duty_of(1)), 0);
    chk("brake_at", 32'(at_target[1]), 0);
    brake[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("brake_off", 32'(ma_of(1)), 32'(exp_off[i]));
    end
    chk("brake_off_duty", 32'(duty_of(1)), 0);
    wait_duty(1, 16'd10, 30, "brake_rerun");
    // clamp and extremes on ch1
    duty_tgt[31:16] = 16'd150;
    wait_at(1, 200, "clamp_at");
    chk("clamp_duty", 32'(duty_of(1)), 100);
    ticks(110);
    count_ma(1, 200, c00, c01, c10, c11);
    chk("clamp_high", c01, 200);
    duty_tgt[31:16] = 16'd0;
    tick();
    wait_at(1, 200, "zero_at");
    chk("zero_duty", 32'(duty_of(1)), 0);
    ticks(110);
    count_ma(1, 200, c00, c01, c10, c11);
    chk("zero_low", c00, 200);
    // enable drop while braking
    brake[1] = 1'b1;
    ticks(6);
    chk("brake2_on", 32'(ma_of(1)), 3);
    enable[1] = 1'b0;
    tick();
    chk("brake2_drop", 32'(ma_of(1)), 0);
    brake[1] = 1'b0;
    ticks(3);
    chk("brake2_idle", 32'(ma_of(1)), 0);
    // abort ch0 mid-ramp
    duty_tgt[15:0] = 16'd100;
    wait_duty(0, 16'd70, 40, "abort_ramp");
    enable[0] = 1'b0;
    tick();
    chk("abort_ma", 32'(ma_of(0)), 0);
    chk("abort_duty", 32'(duty_of(0)), 0);
    chk("abort_at", 32'(at_target[0]), 0);
    // cancel reversal during REV_DOWN
    enable[0] = 1'b1; direct[0] = 1'b1; duty_tgt[15:0] = 16'd60;
    wait_at(0, 200, "cancel_at");
    chk("cancel_duty", 32'(duty_of(0)), 60);
    direct[0] = 1'b0;
    wait_duty(0, 16'd50, 30, "cancel_down");
    chk("cancel_down_at", 32'(at_target[0]), 0);
    direct[0] = 1'b1;
    n = 0;
    mn = 50;
    saw = 1'b0;
    while (at_target[0] !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (int'(duty_of(0)) < mn) mn = int'(duty_of(0));
      if (ma_of(0) === 2'b10) saw = 1'b1;
    end
    chk("cancel_min", mn, 50);
    chk("cancel_no_rev", 32'(saw), 0);
    chk("cancel_back", 32'(duty_of(0)), 60);
    // asynchronous reset mid-run
    n = 0;
    while (ma_of(0) !== 2'b01 && n < 150) begin
      tick();
      n++;
    end
    chk("pre_reset_ma", 32'(ma_of(0)), 1);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("async_ma", 32'(MA), 0);
    chk("async_duty", duty_cur, 0);
    chk("async_at", 32'(at_target), 0);
    enable = '0;
    ticks(3);
    s_rst_n = 1'b1;
    ticks(5);
    chk("post_ma", 32'(MA), 0);
    chk("post_duty", duty_cur, 0);
    enable[0] = 1'b1; direct[0] = 1'b1; duty_tgt[15:0] = 16'd20;
    wait_duty(0, 16'd10, 30, "post_ramp");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
